// File: rtl/reg_trace_capture_if.sv
// reg_trace_capture_if
//   Byte stream carrying trace records from reg_trace_capture to a sink
//   (UART, trace dump, testbench).
//
//   Signals
//     out_data   8  current stream byte (driven by master)
//     out_valid  1  out_data holds a byte (driven by master)
//     out_ready  1  sink can take a byte (driven by slave)
//
//   Handshake: a byte transfers on a rising clk edge where out_valid && out_ready.
//   Once out_valid is raised, the master holds out_data and out_valid
//   unchanged until that transfer happens. The only exception is reset, which
//   abandons the byte. out_valid does not depend on out_ready, and the slave
//   may raise or lower out_ready at any time.
interface reg_trace_capture_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/reg_trace_capture.sv
// reg_trace_capture
//   Watches the register file's 64-bit debug snapshot. Whenever the snapshot
//   differs from the previous cycle's value (and capture is enabled), it queues
//   {cycle stamp, snapshot} in a small FIFO. Queued records are serialised as
//   11-byte records on a valid/ready byte stream:
//     0xA5, stamp[15:8], stamp[7:0], A, M, L, H, E, D, C, B
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     en         in   capture enable (gates new records only; draining continues)
//     regs_flat  in   64-bit snapshot {A,M,L,H,E,D,C,B}, A in [63:56]
//     trace      if   master side of the byte stream (out_data/out_valid/out_ready)
//     count      out  records waiting in the FIFO (excludes the record being sent)
//     overflow   out  sticky: a record was dropped because the FIFO was full
//     dropped    out  saturating count of dropped records
//     dbg_state  out  serializer FSM state (0 = IDLE, 1 = SEND)
module reg_trace_capture #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [63:0]                regs_flat,
  reg_trace_capture_if.master        trace,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 dropped,
  output logic                       dbg_state
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int REC_W  = STAMP_W + 64;
  localparam int SH_W   = REC_W + 8;
  localparam int NBYTES = SH_W / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state_q;
  logic [STAMP_W-1:0]  stamp_q;
  logic [63:0]         prev_q;
  logic [REC_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [SH_W-1:0]     sh_q;
  logic [3:0]          idx_q;
  logic                valid_q;
  logic                overflow_q;
  logic [7:0]          dropped_q;

  logic accept, last_accept, full, pop, push_req, push, drop;

  always_comb begin
    accept      = valid_q && trace.out_ready;
    last_accept = accept && (idx_q == 4'(NBYTES - 1));
    full        = (count_q == CW'(DEPTH));
    // Pop either to start from IDLE or to chain the next record onto the
    // final byte of the current one, so back-to-back records have no bubble.
    pop         = (count_q != '0) && ((state_q == S_IDLE) || last_accept);
    push_req    = en && (regs_flat != prev_q);
    // A full FIFO still accepts a push when a pop frees the head slot on the
    // same edge; the read uses the old head before the write lands.
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
  end

  // Record storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {stamp_q, regs_flat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stamp_q    <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sh_q       <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      stamp_q <= stamp_q + 1'b1;
      prev_q  <= regs_flat;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            sh_q    <= {8'hA5, mem[rd_ptr_q]};
            idx_q   <= '0;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (last_accept) begin
            if (pop) begin
              sh_q  <= {8'hA5, mem[rd_ptr_q]};
              idx_q <= '0;
            end else begin
              valid_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (accept) begin
            // Current byte always sits in the top 8 bits.
            sh_q  <= {sh_q[SH_W-9:0], 8'h00};
            idx_q <= idx_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trace.out_data  = sh_q[SH_W-1 -: 8];
  assign trace.out_valid = valid_q;
  assign count           = count_q;
  assign overflow        = overflow_q;
  assign dropped         = dropped_q;
  assign dbg_state       = state_q;

endmodule
